// File: rtl/power_good_mon.sv
// Rail power-good monitor: drives the regulator enable, filters the synchronized
// comparator output into a qualified power_good, and retries ramp/sag failures before faulting.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// OFF      | regulator off, retry budget cleared, waiting for en_req
// RAMP     | regulator on, waiting for GOOD_CYCLES consecutive high samples
// GOOD     | rail qualified, watching for a sustained sag
// COOLDOWN | regulator held off before the next retry
// FAULT    | retries exhausted, sticky until en_req drops
module power_good_mon #(
    parameter int GOOD_CYCLES     = 16,
    parameter int RAMP_TIMEOUT    = 200,
    parameter int GLITCH_CYCLES   = 3,
    parameter int COOLDOWN_CYCLES = 50,
    parameter int MAX_RETRY       = 2
) (
    input  logic clk,
    input  logic resetb,
    input  logic en_req,
    input  logic vmon_ok,
    output logic reg_en,
    output logic power_good,
    output logic fault
);

    localparam int W_STABLE = (GOOD_CYCLES     > 1) ? $clog2(GOOD_CYCLES + 1)     : 1;
    localparam int W_RAMP   = (RAMP_TIMEOUT    > 1) ? $clog2(RAMP_TIMEOUT + 1)    : 1;
    localparam int W_LOW    = (GLITCH_CYCLES   > 1) ? $clog2(GLITCH_CYCLES + 1)   : 1;
    localparam int W_COOL   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam int W_RETRY  = (MAX_RETRY       > 0) ? $clog2(MAX_RETRY + 1)       : 1;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_RAMP     = 3'd1,
        S_GOOD     = 3'd2,
        S_COOLDOWN = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_vmon_meta;
    logic                r_vmon_s;
    logic [W_STABLE-1:0] r_stable_cnt;
    logic [W_RAMP-1:0]   r_ramp_cnt;
    logic [W_LOW-1:0]    r_low_cnt;
    logic [W_COOL-1:0]   r_cool_cnt;
    logic [W_RETRY-1:0]  r_retry_cnt;

    logic w_qualify;
    logic w_ramp_timeout;
    logic w_sag;
    logic w_cool_done;
    logic w_can_retry;
    logic w_fail;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_vmon_meta <= 1'b0;
            r_vmon_s    <= 1'b0;
        end else begin
            r_vmon_meta <= vmon_ok;
            r_vmon_s    <= r_vmon_meta;
        end
    end

    // Limits are tested against the value the counter would reach on this edge,
    // so each transition lands exactly on the sample that completes the count.
    assign w_qualify      = r_vmon_s  && (r_stable_cnt == W_STABLE'(GOOD_CYCLES - 1));
    assign w_ramp_timeout = (r_ramp_cnt == W_RAMP'(RAMP_TIMEOUT - 1));
    assign w_sag          = !r_vmon_s && (r_low_cnt == W_LOW'(GLITCH_CYCLES - 1));
    assign w_cool_done    = (r_cool_cnt == W_COOL'(COOLDOWN_CYCLES - 1));
    assign w_can_retry    = (r_retry_cnt < W_RETRY'(MAX_RETRY));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        case (r_state)
            S_OFF: begin
                if (en_req) w_state_nxt = S_RAMP;
            end
            S_RAMP: begin
                if (!en_req)             w_state_nxt = S_OFF;
                else if (w_qualify)      w_state_nxt = S_GOOD;
                else if (w_ramp_timeout) w_fail      = 1'b1;
            end
            S_GOOD: begin
                if (!en_req)     w_state_nxt = S_OFF;
                else if (w_sag)  w_fail      = 1'b1;
            end
            S_COOLDOWN: begin
                if (!en_req)          w_state_nxt = S_OFF;
                else if (w_cool_done) w_state_nxt = S_RAMP;
            end
            S_FAULT: begin
                if (!en_req) w_state_nxt = S_OFF;
            end
            default: w_state_nxt = S_OFF;
        endcase
        if (w_fail) begin
            w_state_nxt = w_can_retry ? S_COOLDOWN : S_FAULT;
        end
    end

    // Each counter only runs while its state is held; any exit or entry leaves it at zero.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_stable_cnt <= '0;
            r_ramp_cnt   <= '0;
            r_low_cnt    <= '0;
            r_cool_cnt   <= '0;
            r_retry_cnt  <= '0;
        end else begin
            if (r_state == S_RAMP && w_state_nxt == S_RAMP) begin
                r_ramp_cnt   <= r_ramp_cnt + 1'b1;
                r_stable_cnt <= r_vmon_s ? r_stable_cnt + 1'b1 : '0;
            end else begin
                r_ramp_cnt   <= '0;
                r_stable_cnt <= '0;
            end

            if (r_state == S_GOOD && w_state_nxt == S_GOOD) begin
                r_low_cnt <= r_vmon_s ? '0 : r_low_cnt + 1'b1;
            end else begin
                r_low_cnt <= '0;
            end

            if (r_state == S_COOLDOWN && w_state_nxt == S_COOLDOWN) begin
                r_cool_cnt <= r_cool_cnt + 1'b1;
            end else begin
                r_cool_cnt <= '0;
            end

            if (r_state == S_OFF) begin
                r_retry_cnt <= '0;
            end else if (w_fail && w_can_retry) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        reg_en     = (r_state == S_RAMP) || (r_state == S_GOOD);
        power_good = (r_state == S_GOOD);
        fault      = (r_state == S_FAULT);
    end

endmodule
